// File: rtl/fp_wire_pkg.sv
// Shared types for fp_issue_seq and the fp_unit it drives.
// Queued requests carry tags up to SEQ_TAG_W_MAX bits; narrower TAG_W values are zero-extended.
package fp_wire;

  localparam int          SEQ_TAG_W_MAX = 16;
  localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
  localparam logic [4:0]  FLAG_NV       = 5'b10000;

  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmsub;
    logic       fnmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fp_seq_state_type;

  typedef struct packed {
    logic [31:0]              data1;
    logic [31:0]              data2;
    logic [31:0]              data3;
    logic [1:0]               fmt;
    logic [2:0]               rm;
    fp_operation_type         op;
    logic [SEQ_TAG_W_MAX-1:0] tag;
  } fp_seq_req_type;

endpackage

// File: rtl/fp_issue_seq_fifo.sv
// Request FIFO for fp_issue_seq: power-of-two depth, naturally wrapping pointers.
module fp_seq_fifo
  import fp_wire::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  fp_seq_req_type           data_i,
  input  logic                     pop_i,
  output fp_seq_req_type           data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fp_seq_req_type mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           push;
  logic           pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: the payload array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fp_issue_seq.sv
// Sequencer in front of fp_unit: queues requests, issues one at a time, and returns
// each result in order with sticky accumulated flags and a hang watchdog.
module fp_issue_seq
  import fp_wire::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_data1,
  input  logic [31:0]      req_data2,
  input  logic [31:0]      req_data3,
  input  logic [1:0]       req_fmt,
  input  logic [2:0]       req_rm,
  input  fp_operation_type req_op,
  input  logic [TAG_W-1:0] req_tag,
  output fp_exe_in_type    fp_exe_i,
  input  fp_exe_out_type   fp_exe_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fp_seq_state_type       state_q, state_d;
  fp_seq_req_type         issue_q, issue_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_result_q, rsp_result_d;
  logic [4:0]             rsp_flags_q, rsp_flags_d;
  logic [TAG_W-1:0]       rsp_tag_q, rsp_tag_d;
  logic [4:0]             fflags_q, fflags_d;
  logic                   timeout_q, timeout_d;

  fp_seq_req_type         fifo_in, fifo_head;
  logic                   fifo_pop, fifo_full, fifo_empty, rsp_accept;
  logic [$clog2(DEPTH):0] fifo_count;

  always_comb begin
    fifo_in       = '0;
    fifo_in.data1 = req_data1;
    fifo_in.data2 = req_data2;
    fifo_in.data3 = req_data3;
    fifo_in.fmt   = req_fmt;
    fifo_in.rm    = req_rm;
    fifo_in.op    = req_op;
    fifo_in.tag   = SEQ_TAG_W_MAX'(req_tag);
  end

  fp_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (req_valid),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no branch can infer a latch.
    state_d      = state_q;
    issue_d      = issue_q;
    wait_cnt_d   = wait_cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;
    timeout_d    = timeout_q;
    fifo_pop     = 1'b0;
    rsp_accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          issue_d  = fifo_head;
          state_d  = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        wait_cnt_d = (state_q == ISSUE) ? '0 : wait_cnt_q + CNT_W'(1);
        if (fp_exe_o.ready) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = fp_exe_o.result;
          rsp_flags_d  = fp_exe_o.flags;
          rsp_tag_d    = issue_q.tag[TAG_W-1:0];
          state_d      = RESP;
        end else if (state_q == WAIT && wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // fp_unit is hung: answer with a canonical invalid result so the requester unblocks.
          timeout_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_result_d = FP_QNAN;
          rsp_flags_d  = FLAG_NV;
          rsp_tag_d    = issue_q.tag[TAG_W-1:0];
          state_d      = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          issue_d.op  = init_fp_operation;
          rsp_accept  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fflags_clr)      fflags_d = rsp_accept ? rsp_flags_q : '0;
    else if (rsp_accept) fflags_d = fflags_q | rsp_flags_q;
    else                 fflags_d = fflags_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      issue_q      <= '0;
      wait_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      fflags_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_q      <= issue_d;
      wait_cnt_q   <= wait_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
      fflags_q     <= fflags_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    fp_exe_i        = '0;
    fp_exe_i.data1  = issue_q.data1;
    fp_exe_i.data2  = issue_q.data2;
    fp_exe_i.data3  = issue_q.data3;
    fp_exe_i.fmt    = issue_q.fmt;
    fp_exe_i.rm     = issue_q.rm;
    fp_exe_i.op     = issue_q.op;
    fp_exe_i.enable = (state_q == ISSUE);
  end

  assign req_ready  = !fifo_full;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_tag    = rsp_tag_q;
  assign fflags_acc = fflags_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: doc/fp_issue_seq.md
Name: fp_issue_seq

Overview:
- Request sequencer directly upstream of fp_unit.
- Accepts FP operation requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one operation at a time on the fp_exe_i port as a single-cycle enable pulse, then waits for fp_exe_o.ready.
- Returns result, flags and tag on a valid/ready response port, and keeps a sticky accumulated-flags register (fflags style) plus a watchdog timeout.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the request/response tag.
- TIMEOUT, 64, maximum cycles in WAIT before fp_unit is declared hung.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets all state).
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_data1/req_data2/req_data3  in  32 each  operands.
- req_fmt  in  2  format.
- req_rm  in  3  rounding mode.
- req_op  in  fp_operation_type  operation one-hot.
- req_tag  in  TAG_W  requester tag.
- fp_exe_i  out  fp_exe_in_type  to fp_unit: data1..3, fmt, rm, op, enable.
- fp_exe_o  in  fp_exe_out_type  from fp_unit: result, flags, ready.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  32  result.
- rsp_flags  out  5  NV,DZ,OF,UF,NX in bits 4..0.
- rsp_tag  out  TAG_W  tag of the completed request.
- fflags_acc  out  5  sticky OR of all delivered flags.
- fflags_clr  in  1  clears fflags_acc.
- busy  out  1  FSM not IDLE or FIFO not empty.
- timeout  out  1  sticky hang indicator.

Behaviour:
- Reset values: req_ready=1; all fp_exe_i fields 0 with op=init_fp_operation and enable=0; rsp_valid=0; rsp_result/rsp_flags/rsp_tag=0; fflags_acc=0; busy=0; timeout=0. FIFO pointers and count=0; FSM=IDLE.
- Reset mid-operation drops all queued and in-flight work. A later fp_unit ready is ignored because the FSM is in IDLE.
- FIFO:
  - Push when req_valid && req_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
  - req_ready = count != DEPTH (registered-state based, not dependent on req_valid).
  - Simultaneous push and pop when full is not allowed: full blocks the push. Push and pop at count==1 keeps count=1.
- FSM IDLE/ISSUE/WAIT/RESP:
  - IDLE: if count!=0, pop the head into the issue register and go to ISSUE. A request pushed into an empty FIFO is popped no earlier than the next cycle (min push-to-enable latency 2 cycles).
  - ISSUE: drive fp_exe_i from the issue register with enable=1 for exactly this cycle; go to WAIT.
  - WAIT: enable=0. Operand, fmt, rm and op fields stay held stable; op stays held until ready. The wait counter increments each cycle.
    - On fp_exe_o.ready=1: capture result, flags and tag into the response register, set rsp_valid, go to RESP.
    - If the counter reaches TIMEOUT without ready: set timeout=1, return rsp_result=0x7FC00000, rsp_flags=5'b10000 (NV), go to RESP.
  - RESP: hold rsp_valid and rsp_* stable until rsp_ready. On the accepting cycle: clear rsp_valid, OR rsp_flags into fflags_acc, clear op to init_fp_operation, go to IDLE. No new issue occurs while a response is pending, so results are never dropped.
- ready arriving in the ISSUE cycle itself (zero-latency unit) is accepted identically.
- fflags_acc:
  - fflags_clr and a same-cycle accept: the result is the new flags only (clear first, then OR).
  - fflags_clr alone: 0.
- timeout clears only on reset.
- Response order equals request order (single outstanding operation).

Decomposition:
- fp_wire package: fp_seq_state_type enum (IDLE, ISSUE, WAIT, RESP), fp_seq_req_type struct (data1..3, fmt, rm, op, tag), and constants FP_QNAN=32'h7FC00000 and FLAG_NV=5'b10000.
- One sub-module: fp_seq_fifo (parameterised DEPTH, payload fp_seq_req_type, push/pop/full/empty/count).

Test Plan:
- Single fdiv, data1=0x3F800000, data2=0x40000000, rm=0 (rne), tag=3 -> one-cycle enable, op.fdiv=1 held; rsp_result=0x3F000000, rsp_flags=0, rsp_tag=3, fflags_acc=0.
- fsqrt of 0x40800000 (rne) followed immediately by fdiv 0x3F800000/0x00000000 -> responses in order: 0x40000000/flags 0, then 0x7F800000/flags 0x08; fflags_acc=0x08.
- Push 5 requests with DEPTH=4 while rsp_ready=0 -> req_ready drops after 4 queued + 1 issued. With rsp_ready=1, no further issue until the response is accepted; all 5 tags return in order 0..4.
- Stub fp_unit never asserting ready, TIMEOUT=64 -> enable seen once; on cycle 64 of WAIT, timeout=1, rsp_result=0x7FC00000, rsp_flags=0x10.
- Assert reset=0 asynchronously during WAIT with 2 requests queued -> all outputs at reset values immediately (before next edge). A later stub ready is ignored; count=0.
- fflags_clr asserted in the same cycle as accepting a response with flags 0x01 and prior fflags_acc=0x08 -> fflags_acc=0x01.
